// File: rtl/universal_register_pkg.sv
`default_nettype none
// ============================================================================
// Module   : universal_register_pkg
// Brief    : Shared types for the universal register: sequencer state,
//            operation select and the fixed-priority operation decoder.
// Revision : 1.0  initial release
// ============================================================================
package universal_register_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    typedef enum logic [2:0] {
        OP_NONE   = 3'd0,
        OP_CL     = 3'd1,
        OP_LD     = 3'd2,
        OP_MSTART = 3'd3,
        OP_INC    = 3'd4,
        OP_DEC    = 3'd5,
        OP_SR     = 3'd6,
        OP_SL     = 3'd7
    } op_e;

    // Highest-priority request wins; everything below it is ignored.
    function automatic op_e decode_op(input logic cl, input logic ld,
                                      input logic mstart, input logic inc,
                                      input logic dec, input logic sr,
                                      input logic sl);
        if (cl)          return OP_CL;
        else if (ld)     return OP_LD;
        else if (mstart) return OP_MSTART;
        else if (inc)    return OP_INC;
        else if (dec)    return OP_DEC;
        else if (sr)     return OP_SR;
        else if (sl)     return OP_SL;
        else             return OP_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/universal_register_shseq.sv
`default_nettype none
// ============================================================================
// Module   : universal_register_shseq
// Brief    : Shift-count sequencer for multi-cycle shifts. Accepts a start
//            request with an amount (clamped to W), stays busy for that many
//            cycles and pulses done once; an abort drops back to IDLE
//            without a done pulse.
// Revision : 1.0  initial release
// ============================================================================
module universal_register_shseq
    import universal_register_pkg::*;
#(
    parameter  int W   = 4,
    localparam int SHW = $clog2(W + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [SHW-1:0] shamt,
    input  logic           abort,
    output logic           busy,
    output logic           done
);

    localparam logic [SHW-1:0] c_max_amt = SHW'(W);
    localparam logic [SHW-1:0] c_one     = SHW'(1);

    state_e         r_state;
    state_e         w_state_nxt;
    logic [SHW-1:0] r_count;
    logic [SHW-1:0] w_count_nxt;
    logic           r_done;
    logic           w_done_nxt;
    logic [SHW-1:0] w_amt;

    // Amounts above W cannot be represented in a W-bit register; clamp them.
    assign w_amt = (shamt > c_max_amt) ? c_max_amt : shamt;

    // State, remaining count and done pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_count <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state logic: a zero-length request only produces the done pulse.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (w_amt == '0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = SHIFT;
                        w_count_nxt = w_amt;
                    end
                end
            end
            SHIFT: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                    w_count_nxt = '0;
                end else begin
                    w_count_nxt = r_count - c_one;
                    if (r_count == c_one) begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_count_nxt = '0;
            end
        endcase
    end

    assign busy = (r_state == SHIFT);
    assign done = r_done;

endmodule
`default_nettype wire

// File: rtl/universal_register_n.sv
`default_nettype none
// ============================================================================
// Module   : universal_register_n
// Brief    : W-bit universal register: clear, parallel load, up/down count,
//            1-bit shift/rotate and multi-cycle N-bit shift with busy/done,
//            plus carry and zero flags.
//            Build option UNIVERSAL_REGISTER_SAT_EN: saturating inc/dec
//            (default build wraps around).
// Revision : 1.0  initial release
// ============================================================================
module universal_register_n
    import universal_register_pkg::*;
#(
    parameter  int W   = 4,
    localparam int SHW = $clog2(W + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cl,
    input  logic           ld,
    input  logic [W-1:0]   in,
    input  logic           inc,
    input  logic           dec,
    input  logic           sr,
    input  logic           ir,
    input  logic           sl,
    input  logic           il,
    input  logic           rot,
    input  logic           mstart,
    input  logic           mdir,
    input  logic [SHW-1:0] shamt,
    output logic [W-1:0]   out,
    output logic           carry,
    output logic           zero,
    output logic           busy,
    output logic           done
);

    localparam logic [W-1:0] c_one = W'(1);

    op_e          w_op;
    logic         w_busy;
    logic         w_start;
    logic         w_abort;
    logic [W-1:0] r_out;
    logic [W-1:0] w_out_nxt;
    logic         r_carry;
    logic         w_carry_nxt;
    logic         r_mdir;
    logic         r_mrot;
    logic         w_rot_sel;
    logic [W-1:0] w_shr;
    logic [W-1:0] w_shl;
    logic         w_all1;
    logic         w_all0;

    assign w_op    = decode_op(cl, ld, mstart, inc, dec, sr, sl);
    assign w_start = !w_busy && (w_op == OP_MSTART);
    assign w_abort = w_busy && (cl || ld);

    universal_register_shseq #(.W(W)) u_shseq (
        .clk   (clk),
        .rst_n (rst_n),
        .start (w_start),
        .shamt (shamt),
        .abort (w_abort),
        .busy  (w_busy),
        .done  (done)
    );

    // A multi-shift uses the direction and rotate mode captured at accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mdir <= 1'b0;
            r_mrot <= 1'b0;
        end else if (w_start) begin
            r_mdir <= mdir;
            r_mrot <= rot;
        end
    end

    // Shift candidates; serial inputs are always sampled live.
    assign w_rot_sel = w_busy ? r_mrot : rot;
    assign w_shr     = {(w_rot_sel ? r_out[0]   : ir), r_out[W-1:1]};
    assign w_shl     = {r_out[W-2:0], (w_rot_sel ? r_out[W-1] : il)};
    assign w_all1    = &r_out;
    assign w_all0    = ~|r_out;

    // Next register value and carry for the selected operation.
    always_comb begin
        w_out_nxt   = r_out;
        w_carry_nxt = r_carry;
        if (w_busy) begin
            if (cl) begin
                w_out_nxt   = '0;
                w_carry_nxt = 1'b0;
            end else if (ld) begin
                w_out_nxt = in;
            end else if (r_mdir) begin
                w_out_nxt   = w_shl;
                w_carry_nxt = r_out[W-1];
            end else begin
                w_out_nxt   = w_shr;
                w_carry_nxt = r_out[0];
            end
        end else begin
            case (w_op)
                OP_CL: begin
                    w_out_nxt   = '0;
                    w_carry_nxt = 1'b0;
                end
                OP_LD: w_out_nxt = in;
                OP_INC: begin
                    w_out_nxt   = r_out + c_one;
                    w_carry_nxt = w_all1;
`ifdef UNIVERSAL_REGISTER_SAT_EN
                    if (w_all1) w_out_nxt = r_out;
`endif
                end
                OP_DEC: begin
                    w_out_nxt   = r_out - c_one;
                    w_carry_nxt = w_all0;
`ifdef UNIVERSAL_REGISTER_SAT_EN
                    if (w_all0) w_out_nxt = r_out;
`endif
                end
                OP_SR: begin
                    w_out_nxt   = w_shr;
                    w_carry_nxt = r_out[0];
                end
                OP_SL: begin
                    w_out_nxt   = w_shl;
                    w_carry_nxt = r_out[W-1];
                end
                default: begin
                    w_out_nxt   = r_out;
                    w_carry_nxt = r_carry;
                end
            endcase
        end
    end

    // Register contents and carry flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out   <= '0;
            r_carry <= 1'b0;
        end else begin
            r_out   <= w_out_nxt;
            r_carry <= w_carry_nxt;
        end
    end

    assign out   = r_out;
    assign carry = r_carry;
    assign zero  = (r_out == '0);
    assign busy  = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_universal_register_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_universal_register_n
// Brief    : Self-checking bench for universal_register_n (W=4): arithmetic
//            reference model compared every cycle, plus hand-computed
//            literal expectations on directed sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_universal_register_n;

    localparam int W   = 4;
    localparam int SHW = $clog2(W + 1);
    localparam int MOD = 1 << W;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b1;
    logic           cl, ld, inc, dec, sr, ir, sl, il, rot, mstart, mdir;
    logic [W-1:0]   in_d;
    logic [SHW-1:0] shamt;
    logic [W-1:0]   out;
    logic           carry, zero, busy, done;

    universal_register_n #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .cl(cl), .ld(ld), .in(in_d), .inc(inc),
        .dec(dec), .sr(sr), .ir(ir), .sl(sl), .il(il), .rot(rot),
        .mstart(mstart), .mdir(mdir), .shamt(shamt), .out(out),
        .carry(carry), .zero(zero), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Reference model state (plain integers)
    int m_out   = 0;
    bit m_carry = 1'b0;
    bit m_busy  = 1'b0;
    bit m_done  = 1'b0;
    bit m_dir   = 1'b0;
    bit m_rot   = 1'b0;
    int m_left  = 0;

    int n_vec  = 0;
    int n_fail = 0;

    // Literal expectation mailbox: driver posts, compare process consumes
    int    lit_req  = 0;
    int    lit_seen = 0;
    string lit_name = "";
    int    lit_out  = 0;
    bit    lit_carry, lit_busy, lit_done;

    task automatic m_reset();
        m_out = 0; m_carry = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
    endtask

    task automatic m_shift(input bit left, input bit rt);
        int b;
        if (!left) begin
            b     = m_out % 2;
            m_out = (m_out / 2) + ((rt ? b : int'(ir)) * (MOD / 2));
        end else begin
            b     = m_out / (MOD / 2);
            m_out = ((m_out * 2) % MOD) + (rt ? b : int'(il));
        end
        m_carry = (b != 0);
    endtask

    task automatic model_step();
        bit nd;
        int amt;
        nd = 1'b0;
        if (m_busy) begin
            if (cl) begin
                m_out = 0; m_carry = 1'b0; m_busy = 1'b0;
            end else if (ld) begin
                m_out = int'(in_d); m_busy = 1'b0;
            end else begin
                m_shift(m_dir, m_rot);
                m_left = m_left - 1;
                if (m_left == 0) begin m_busy = 1'b0; nd = 1'b1; end
            end
        end else if (cl) begin
            m_out = 0; m_carry = 1'b0;
        end else if (ld) begin
            m_out = int'(in_d);
        end else if (mstart) begin
            amt = (int'(shamt) > W) ? W : int'(shamt);
            if (amt == 0) nd = 1'b1;
            else begin m_busy = 1'b1; m_left = amt; m_dir = mdir; m_rot = rot; end
        end else if (inc) begin
            m_carry = (m_out == MOD - 1);
`ifdef UNIVERSAL_REGISTER_SAT_EN
            if (m_out != MOD - 1) m_out = m_out + 1;
`else
            m_out = (m_out + 1) % MOD;
`endif
        end else if (dec) begin
            m_carry = (m_out == 0);
`ifdef UNIVERSAL_REGISTER_SAT_EN
            if (m_out != 0) m_out = m_out - 1;
`else
            m_out = (m_out + MOD - 1) % MOD;
`endif
        end else if (sr) begin
            m_shift(1'b0, rot);
        end else if (sl) begin
            m_shift(1'b1, rot);
        end
        m_done = nd;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic clr_in();
        cl = 0; ld = 0; inc = 0; dec = 0; sr = 0; ir = 0; sl = 0; il = 0;
        rot = 0; mstart = 0; mdir = 0; in_d = '0; shamt = '0;
    endtask

    task automatic lit(input string nm, input int o, input bit c,
                       input bit b, input bit d);
        lit_name = nm; lit_out = o; lit_carry = c; lit_busy = b; lit_done = d;
        lit_req = lit_req + 1;
    endtask

    // Single compare process: model every cycle, literal when posted
    initial begin
        forever begin
            @(negedge clk or negedge rst_n);
            #1;
            n_vec = n_vec + 1;
            if (out !== m_out[W-1:0] || carry !== m_carry || zero !== (m_out == 0)
                || busy !== m_busy || done !== m_done) begin
                n_fail = n_fail + 1;
                $display("FAIL model t=%0t dut out=%h carry=%b zero=%b busy=%b done=%b, expected out=%h carry=%b zero=%b busy=%b done=%b",
                         $time, out, carry, zero, busy, done, m_out[W-1:0],
                         m_carry, (m_out == 0), m_busy, m_done);
            end
            if (lit_req != lit_seen) begin
                lit_seen = lit_req;
                n_vec    = n_vec + 1;
                if (out !== lit_out[W-1:0] || carry !== lit_carry || zero !== (lit_out == 0)
                    || busy !== lit_busy || done !== lit_done) begin
                    n_fail = n_fail + 1;
                    $display("FAIL %s t=%0t dut out=%h carry=%b zero=%b busy=%b done=%b, expected out=%h carry=%b zero=%b busy=%b done=%b",
                             lit_name, $time, out, carry, zero, busy, done,
                             lit_out[W-1:0], lit_carry, (lit_out == 0), lit_busy, lit_done);
                end
            end
        end
    end

    // Directed sequences followed by random control traffic
    initial begin
        cl = 1'($urandom); ld = 1'($urandom); inc = 1'($urandom);
        dec = 1'($urandom); sr = 1'($urandom); ir = 1'($urandom);
        sl = 1'($urandom); il = 1'($urandom); rot = 1'($urandom);
        mstart = 1'($urandom); mdir = 1'($urandom);
        in_d = W'($urandom); shamt = SHW'($urandom);
        #7;
        rst_n = 1'b0; m_reset(); lit("reset", 0, 0, 0, 0);
        #5;
        rst_n = 1'b1; clr_in();
        tick();

        ld = 1; in_d = 4'hF; tick(); lit("ld_f", 'hF, 0, 0, 0);
        clr_in(); inc = 1; tick();
`ifdef UNIVERSAL_REGISTER_SAT_EN
        lit("inc_sat", 'hF, 1, 0, 0);
`else
        lit("inc_wrap", 0, 1, 0, 0);
`endif
        clr_in(); cl = 1; tick(); lit("clear", 0, 0, 0, 0);
        clr_in(); dec = 1; tick();
`ifdef UNIVERSAL_REGISTER_SAT_EN
        lit("dec_sat", 0, 1, 0, 0);
`else
        lit("dec_wrap", 'hF, 1, 0, 0);
`endif
        clr_in(); cl = 1; ld = 1; inc = 1; sr = 1; in_d = 4'h5; tick();
        lit("prio_cl", 0, 0, 0, 0);
        clr_in(); ld = 1; inc = 1; in_d = 4'h5; tick(); lit("prio_ld", 5, 0, 0, 0);

        // multi-shift right, shifting ones in
        clr_in(); ld = 1; in_d = 4'h9; tick();
        clr_in(); mstart = 1; shamt = 3; ir = 1; tick(); lit("ms_accept", 9, 0, 1, 0);
        clr_in(); ir = 1;
        tick(); lit("ms_s1", 'hC, 1, 1, 0);
        tick(); lit("ms_s2", 'hE, 0, 1, 0);
        tick(); lit("ms_done", 'hF, 0, 0, 1);
        tick(); lit("ms_after", 'hF, 0, 0, 0);

        // multi-shift rotate right; rot dropped after accept
        clr_in(); ld = 1; in_d = 4'h9; tick();
        clr_in(); mstart = 1; rot = 1; shamt = 3; tick(); lit("rot_accept", 9, 0, 1, 0);
        clr_in(); tick(); tick(); tick(); lit("rot_done", 3, 0, 0, 1);

        // abort by load on second busy cycle
        clr_in(); ld = 1; in_d = 4'hA; tick();
        clr_in(); mstart = 1; mdir = 1; shamt = 4; tick(); lit("ab_accept", 'hA, 0, 1, 0);
        clr_in(); tick(); lit("ab_s1", 4, 1, 1, 0);
        ld = 1; in_d = 4'h3; tick(); lit("ab_load", 3, 1, 0, 0);
        clr_in(); tick(); lit("ab_nodone", 3, 1, 0, 0);

        // zero-length request
        mstart = 1; shamt = 0; tick(); lit("ms_zero", 3, 1, 0, 1);
        clr_in(); tick(); lit("ms_zero_after", 3, 1, 0, 0);

        // clamped amount, rotate left; inc/mstart while busy are ignored
        mstart = 1; mdir = 1; rot = 1; shamt = 7; tick();
        clr_in(); inc = 1; mstart = 1; shamt = 1;
        tick(); tick(); tick(); tick(); lit("ms_clamp", 3, 1, 0, 1);

        // single-bit shifts
        clr_in(); sr = 1; ir = 1; tick(); lit("sr_ir1", 9, 1, 0, 0);
        clr_in(); sl = 1; il = 0; tick(); lit("sl_il0", 2, 1, 0, 0);

        for (int i = 0; i < 600; i++) begin
            cl     = ($urandom_range(0, 19) == 0);
            ld     = ($urandom_range(0, 9) == 0);
            mstart = ($urandom_range(0, 5) == 0);
            inc    = ($urandom_range(0, 3) == 0);
            dec    = ($urandom_range(0, 3) == 0);
            sr     = ($urandom_range(0, 3) == 0);
            sl     = ($urandom_range(0, 3) == 0);
            ir = 1'($urandom); il = 1'($urandom);
            rot = 1'($urandom); mdir = 1'($urandom);
            in_d = W'($urandom); shamt = SHW'($urandom);
            if (i % 150 == 75) begin
                rst_n = 1'b0; m_reset();
                #2;
                rst_n = 1'b1;
            end
            tick();
        end

        clr_in(); tick(); tick();
        #10;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
